// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter.
// Op encoding, op typedef and the WIDTH legality helper.
package shifter_pkg;

  typedef logic [1:0] op_t;

  localparam op_t OP_LSL = 2'b00;
  localparam op_t OP_LSR = 2'b01;
  localparam op_t OP_ASR = 2'b10;
  localparam op_t OP_ROR = 2'b11;

  function automatic bit is_pow2(input int unsigned w);
    return (w >= 2) && ((w & (w - 1)) == 0);
  endfunction

endpackage

// File: rtl/shifter_stage.sv
// One register slice of the shifter: shifts by 2^STAGE when
// amt bit STAGE is set. ld_i is this slice's ready (load enable).
// Ports: up_* beat from upstream, *_o registered beat downstream.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4,
  parameter int AMT_W = 5,
  parameter int STAGE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_i,
  input  logic             up_valid_i,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [AMT_W-1:0] up_amt_i,
  input  op_t              up_op_i,
  input  logic [TAG_W-1:0] up_tag_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [AMT_W-1:0] amt_o,
  output op_t              op_o,
  output logic [TAG_W-1:0] tag_o
);

  localparam int D = 1 << STAGE;

  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic [AMT_W-1:0] amt_q;
  op_t              op_q;
  logic [TAG_W-1:0] tag_q;

  // ASR keeps the sign bit in place at every stage, so the
  // current MSB is always the original operand's MSB.
  always_comb begin
    data_d = up_data_i;
    if (up_amt_i[STAGE]) begin
      unique case (up_op_i)
        OP_LSL:  data_d = up_data_i << D;
        OP_LSR:  data_d = up_data_i >> D;
        OP_ASR:  data_d = $signed(up_data_i) >>> D;
        OP_ROR:  data_d = (up_data_i >> D)
                        | (up_data_i << (WIDTH - D));
        default: data_d = up_data_i;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      amt_q   <= '0;
      op_q    <= OP_LSL;
      tag_q   <= '0;
    end else if (ld_i) begin
      valid_q <= up_valid_i;
      if (up_valid_i) begin
        data_q <= data_d;
        amt_q  <= up_amt_i;
        op_q   <= up_op_i;
        tag_q  <= up_tag_i;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign amt_o   = amt_q;
  assign op_o    = op_q;
  assign tag_o   = tag_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// SHIFT_W-stage barrel shifter (LSL/LSR/ASR/ROR) with tag and
// valid/ready on both sides; in_* upstream, out_* downstream.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int TAG_W   = 4,
  localparam int SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_amt,
  input  op_t                in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [TAG_W-1:0]   out_tag
);

  if (!is_pow2(WIDTH)) begin : g_bad_width
    $error("WIDTH must be a power of two >= 2");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("TAG_W must be >= 1");
  end

  // Index 0 is the input port; index i+1 is stage i's register.
  logic [SHIFT_W:0]              v;
  logic [SHIFT_W:0][WIDTH-1:0]   d;
  logic [SHIFT_W:0][SHIFT_W-1:0] a;
  op_t  [SHIFT_W:0]              o;
  logic [SHIFT_W:0][TAG_W-1:0]   t;
  logic [SHIFT_W:0]              rdy;

  assign v[0] = in_valid;
  assign d[0] = in_data;
  assign a[0] = in_amt;
  assign o[0] = in_op;
  assign t[0] = in_tag;

  // A stage can load if it is empty or everything below it
  // can move, so bubbles collapse under a stalled output.
  always_comb begin
    logic acc;
    acc = out_ready;
    rdy = '0;
    rdy[SHIFT_W] = out_ready;
    for (int i = SHIFT_W - 1; i >= 0; i--) begin
      acc    = acc | ~v[i+1];
      rdy[i] = acc;
    end
  end

  for (genvar i = 0; i < SHIFT_W; i++) begin : g_stage
    shifter_stage #(
      .WIDTH (WIDTH),
      .TAG_W (TAG_W),
      .AMT_W (SHIFT_W),
      .STAGE (i)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .ld_i       (rdy[i]),
      .up_valid_i (v[i]),
      .up_data_i  (d[i]),
      .up_amt_i   (a[i]),
      .up_op_i    (o[i]),
      .up_tag_i   (t[i]),
      .valid_o    (v[i+1]),
      .data_o     (d[i+1]),
      .amt_o      (a[i+1]),
      .op_o       (o[i+1]),
      .tag_o      (t[i+1])
    );
  end

  // Amount and op are spent once the last stage has shifted.
  logic unused_tail;
  assign unused_tail = ^{a[SHIFT_W], o[SHIFT_W]};

  assign in_ready  = rdy[0];
  assign out_valid = v[SHIFT_W];
  assign out_data  = d[SHIFT_W];
  assign out_tag   = t[SHIFT_W];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter at WIDTH=8, TAG_W=4.
// Vector table, corner sequences, and a scoreboarded random run.
module tb_pipelined_barrel_shifter;

  localparam int W  = 8;
  localparam int TW = 4;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [SW-1:0] in_amt = '0;
  logic [1:0]    in_op = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(
    .WIDTH (W),
    .TAG_W (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  typedef struct {
    logic [7:0] d;
    logic [3:0] t;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic [2:0] a;
    logic [1:0] o;
    logic [3:0] t;
    logic [7:0] e;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   out_total = 0;
  int   last_out_cyc = 0;
  exp_t q[$];
  logic       hold_prev = 1'b0;
  logic [7:0] hold_d = '0;
  logic [3:0] hold_t = '0;

  // Reference: plain integer arithmetic on the operand value.
  function automatic logic [7:0] ref_shift(input logic [7:0] d,
                                           input logic [2:0] a,
                                           input logic [1:0] o);
    int v;
    int p;
    int r;
    v = int'(d);
    p = 1 << a;
    case (o)
      2'd0: r = (v * p) % 256;
      2'd1: r = v / p;
      2'd2: begin
        if (v >= 128) v = v - 256;
        r = (v >= 0) ? v / p : -((-v + p - 1) / p);
      end
      default: begin
        r = v;
        repeat (a) r = (r % 2) * 128 + r / 2;
      end
    endcase
    return 8'(r & 255);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge rst) q.delete();

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      hold_prev <= 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_d);
        check("hold_tag", out_tag, hold_t);
      end
      hold_prev <= out_valid && !out_ready;
      hold_d    <= out_data;
      hold_t    <= out_tag;
      if (in_valid && in_ready)
        q.push_back('{ref_shift(in_data, in_amt, in_op), in_tag});
      if (out_valid && out_ready) begin
        out_total    <= out_total + 1;
        last_out_cyc <= cyc;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_spurious: got 0x%0h expected none",
                   out_data);
        end else begin
          check("sb_data", out_data, q[0].d);
          check("sb_tag", out_tag, q[0].t);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] a,
                      input logic [1:0] o, input logic [3:0] t);
    int g;
    g = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_op    = o;
    in_tag   = t;
    while (!in_ready && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts edges from the acceptance edge (edge 1).
  task automatic run_vec(input string name, input vec_t v);
    int lat;
    send(v.d, v.a, v.o, v.t);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_data"}, out_data, v.e);
    check({name, "_tag"}, out_tag, v.t);
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    int   n0;
    int   s;
    int   acc;
    int   stalls;
    int   sent;
    logic [7:0]  hd;
    logic [10:0] iv;

    tbl[0] = '{8'h81, 3'd1, 2'd0, 4'h3, 8'h02};
    tbl[1] = '{8'h80, 3'd3, 2'd1, 4'h1, 8'h10};
    tbl[2] = '{8'h80, 3'd3, 2'd2, 4'h2, 8'hF0};
    tbl[3] = '{8'h7F, 3'd7, 2'd2, 4'h4, 8'h00};
    tbl[4] = '{8'h01, 3'd1, 2'd3, 4'h5, 8'h80};
    tbl[5] = '{8'hA5, 3'd4, 2'd3, 4'h6, 8'h5A};
    tbl[6] = '{8'hC3, 3'd0, 2'd0, 4'h7, 8'hC3};
    tbl[7] = '{8'hC3, 3'd0, 2'd1, 4'h8, 8'hC3};
    tbl[8] = '{8'hC3, 3'd0, 2'd2, 4'h9, 8'hC3};
    tbl[9] = '{8'hC3, 3'd0, 2'd3, 4'hA, 8'hC3};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    // Streaming: every data x amt pair, random op per beat.
    n0 = out_total;
    stalls = 0;
    s = cyc;
    for (int i = 0; i < 2048; i++) begin
      iv = 11'(i);
      if (!in_ready) stalls++;
      send(iv[7:0], iv[10:8], 2'($urandom), 4'($urandom));
    end
    repeat (6) @(posedge clk);
    #1;
    check("stream_stalls", stalls, 0);
    check("stream_count", out_total - n0, 2048);
    check("stream_last_cycle", last_out_cyc - s, 2050);

    // Backpressure: three beats fill the pipe, then stall.
    out_ready = 1'b0;
    n0 = out_total;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      in_amt   = 3'($urandom);
      in_op    = 2'($urandom);
      in_tag   = 4'($urandom);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    check("bp_accepted", acc, 3);
    check("bp_in_ready_low", in_ready, 0);
    hd = out_data;
    repeat (3) @(posedge clk);
    #1;
    check("bp_out_valid", out_valid, 1);
    check("bp_data_stable", out_data, hd);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 1);
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained", out_total - n0, 3);

    // Bubble: B closes up behind a stalled A.
    out_ready = 1'b0;
    send(8'hF0, 3'd2, 2'd1, 4'h5);
    @(posedge clk); #1;
    send(8'h0F, 3'd2, 2'd3, 4'h6);
    repeat (4) @(posedge clk);
    #1;
    check("bub_a_valid", out_valid, 1);
    check("bub_a_data", out_data, 8'h3C);
    check("bub_a_tag", out_tag, 4'h5);
    check("bub_in_ready", in_ready, 1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bub_b_valid", out_valid, 1);
    check("bub_b_data", out_data, 8'hC3);
    check("bub_b_tag", out_tag, 4'h6);
    @(posedge clk); #1;
    check("bub_empty", out_valid, 0);

    // Reset with three beats in flight.
    send(8'h11, 3'd1, 2'd0, 4'h1);
    send(8'h22, 3'd2, 2'd1, 4'h2);
    send(8'h33, 3'd3, 2'd3, 4'h3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check("post_rst_idle", out_valid, 0);
    end
    run_vec("post_rst", tbl[0]);

    // Random traffic with random backpressure.
    sent = 0;
    for (int k = 0; k < 4000 && sent < 600; k++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      in_amt    = 3'($urandom);
      in_op     = 2'($urandom);
      in_tag    = 4'($urandom);
      out_ready = ($urandom_range(2) != 0);
      #1;
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("rand_sent", sent, 600);
    check("final_queue_empty", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
